// File: rtl/thermal_fb_port.sv
// Frame-buffer port controller: merges a buffered sensor write stream and random display
// reads onto one single-port frame RAM, with sequential frame addressing and completion pulse.
module thermal_fb_port #(
    parameter int DW           = 16,
    parameter int AW           = 10,
    parameter int FRAME_PIXELS = 768,
    parameter int WF_AW        = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_sof,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wr,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rd,
    output logic          frame_done,
    output logic [7:0]    frame_cnt
);

    localparam int              DEPTH     = 1 << WF_AW;
    localparam logic [AW-1:0]   LAST_ADDR = AW'(FRAME_PIXELS - 1);
    localparam logic [AW-1:0]   ADDR_ONE  = AW'(1);
    localparam logic [WF_AW-1:0] PTR_ONE  = WF_AW'(1);
    localparam logic [WF_AW:0]  CNT_ONE   = (WF_AW + 1)'(1);

    logic [DW:0]       fifo_mem [DEPTH];
    logic [WF_AW-1:0]  head_ptr;
    logic [WF_AW-1:0]  tail_ptr;
    logic [WF_AW:0]    fifo_count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              head_sof;
    logic [DW-1:0]     head_data;

    logic              write_grant;
    logic              read_grant;
    logic [AW-1:0]     write_addr;
    logic [AW-1:0]     waddr;
    logic [AW-1:0]     addr_hold;
    logic              vld_p1;
    logic              frame_done_p1;

    function automatic logic [AW-1:0] next_waddr(input logic [AW-1:0] used);
        return (used == LAST_ADDR) ? '0 : used + ADDR_ONE;
    endfunction

    // Count tops out at DEPTH, so its MSB alone marks a full FIFO.
    assign full     = fifo_count[WF_AW];
    assign empty    = (fifo_count == '0);
    assign wr_ready = !full;
    assign rd_ready = !full;
    assign push     = wr_valid && !full;
    assign pop      = write_grant;

    assign {head_sof, head_data} = fifo_mem[head_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr   <= '0;
            tail_ptr   <= '0;
            fifo_count <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + PTR_ONE;
            if (pop)  head_ptr <= head_ptr + PTR_ONE;
            if (push && !pop)
                fifo_count <= fifo_count + CNT_ONE;
            else if (pop && !push)
                fifo_count <= fifo_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[tail_ptr] <= {wr_sof, wr_data};
    end

    // p0: per-cycle arbitration of the single RAM port
    always_comb begin
        write_grant = !empty && (full || !rd_req);
        read_grant  = rd_req && !full;
        write_addr  = head_sof ? '0 : waddr;
        ram_we      = write_grant;
        ram_wr      = head_data;
        ram_addr    = addr_hold;
        if (write_grant)
            ram_addr = write_addr;
        else if (read_grant)
            ram_addr = rd_addr;
    end

    // p1: read result valid, frame completion and address bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr         <= '0;
            addr_hold     <= '0;
            vld_p1        <= 1'b0;
            frame_done_p1 <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            addr_hold     <= ram_addr;
            vld_p1        <= read_grant;
            frame_done_p1 <= write_grant && (write_addr == LAST_ADDR);
            if (write_grant) begin
                waddr <= next_waddr(write_addr);
                if (write_addr == LAST_ADDR) frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    assign rd_valid   = vld_p1;
    assign rd_data    = ram_rd;
    assign frame_done = frame_done_p1;

endmodule

// File: tb/tb_thermal_fb_port.sv
// Directed bench for thermal_fb_port: a RAM model behind the main instance, plus a
// small-frame instance used to reach the frame counter wrap quickly.
module tb_thermal_fb_port;

    localparam int DW  = 16;
    localparam int AW  = 10;
    localparam int FP  = 768;
    localparam int SFP = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          wr_sof;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wr;
    logic          ram_we;
    logic [DW-1:0] ram_rd;
    logic          frame_done;
    logic [7:0]    frame_cnt;

    logic          s_wr_valid;
    logic          s_wr_ready;
    logic [DW-1:0] s_wr_data;
    logic          s_wr_sof;
    logic          s_rd_req;
    logic [AW-1:0] s_rd_addr;
    logic          s_rd_ready;
    logic          s_rd_valid;
    logic [DW-1:0] s_rd_data;
    logic [AW-1:0] s_ram_addr;
    logic [DW-1:0] s_ram_wr;
    logic          s_ram_we;
    logic [DW-1:0] s_ram_rd;
    logic          s_frame_done;
    logic [7:0]    s_frame_cnt;

    thermal_fb_port #(.DW(DW), .AW(AW), .FRAME_PIXELS(FP), .WF_AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_sof(wr_sof),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_we(ram_we), .ram_rd(ram_rd),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    thermal_fb_port #(.DW(DW), .AW(AW), .FRAME_PIXELS(SFP), .WF_AW(2)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(s_wr_valid), .wr_ready(s_wr_ready), .wr_data(s_wr_data), .wr_sof(s_wr_sof),
        .rd_req(s_rd_req), .rd_addr(s_rd_addr), .rd_ready(s_rd_ready),
        .rd_valid(s_rd_valid), .rd_data(s_rd_data),
        .ram_addr(s_ram_addr), .ram_wr(s_ram_wr), .ram_we(s_ram_we), .ram_rd(s_ram_rd),
        .frame_done(s_frame_done), .frame_cnt(s_frame_cnt)
    );

    always #5 clk = ~clk;

    // Single-port RAM: registered read, output held on write cycles.
    logic [DW-1:0] ram_mem [1 << AW];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wr;
        else        ram_rd <= ram_mem[ram_addr];
    end

    logic [AW-1:0] wlog_addr [$];
    logic [DW-1:0] wlog_data [$];
    int ncyc       = 0;
    int w_last_cyc = -100;
    int done_cyc   = -1;
    int done_cnt   = 0;
    int s_done_cnt = 0;

    always @(negedge clk) begin
        if (ram_we) begin
            wlog_addr.push_back(ram_addr);
            wlog_data.push_back(ram_wr);
            if (ram_addr == AW'(FP - 1)) w_last_cyc = ncyc;
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = ncyc;
        end
        if (s_frame_done) s_done_cnt++;
        ncyc++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pre_val(input int a);
        return (a == 5) ? 32'hABCD : 32'(32'h1000 + a);
    endfunction

    int base;
    int bad;
    int acc;
    int done_before;
    logic drop_seen;
    logic prev_acc;
    int exp_q [$];

    initial begin
        rst_n = 1'b0;
        wr_valid = 1'b0; wr_data = '0; wr_sof = 1'b0;
        rd_req = 1'b0; rd_addr = '0;
        s_wr_valid = 1'b0; s_wr_data = '0; s_wr_sof = 1'b0;
        s_rd_req = 1'b0; s_rd_addr = '0; s_ram_rd = '0;

        // Reset values
        repeat (3) step();
        check_val("rst_wr_ready", 32'(wr_ready), 1);
        check_val("rst_rd_ready", 32'(rd_ready), 1);
        check_val("rst_rd_valid", 32'(rd_valid), 0);
        check_val("rst_ram_we", 32'(ram_we), 0);
        check_val("rst_ram_addr", 32'(ram_addr), 0);
        check_val("rst_frame_done", 32'(frame_done), 0);
        check_val("rst_frame_cnt", 32'(frame_cnt), 0);
        rst_n = 1'b1;

        // One full frame, no reads
        base = wlog_addr.size();
        done_before = done_cnt;
        for (int i = 0; i < FP; i++) begin
            step();
            wr_valid = 1'b1; wr_data = DW'(i); wr_sof = (i == 0);
        end
        step();
        wr_valid = 1'b0; wr_sof = 1'b0;
        repeat (3) step();
        check_val("frame_write_count", 32'(wlog_addr.size() - base), FP);
        bad = 0;
        for (int j = 0; j < FP && base + j < wlog_addr.size(); j++)
            if (wlog_addr[base + j] != AW'(j) || wlog_data[base + j] != DW'(j)) bad++;
        check_val("frame_order_bad", 32'(bad), 0);
        check_val("frame_done_pulses", 32'(done_cnt - done_before), 1);
        check_val("frame_done_delay", 32'(done_cyc - w_last_cyc), 1);
        check_val("frame_cnt_one", 32'(frame_cnt), 1);

        base = wlog_addr.size();
        step(); wr_valid = 1'b1; wr_data = 16'h1111; wr_sof = 1'b0;
        step(); wr_valid = 1'b0;
        repeat (2) step();
        check_val("next_frame_cnt", 32'(wlog_addr.size() - base), 1);
        check_val("next_frame_addr", 32'(wlog_addr[base]), 0);

        // Preload 0..5 (addr 5 = 0xABCD), then a single read
        for (int i = 0; i < 6; i++) begin
            step();
            wr_valid = 1'b1; wr_sof = (i == 0);
            wr_data = (i == 5) ? 16'hABCD : 16'(32'h1000 + i);
        end
        step(); wr_valid = 1'b0; wr_sof = 1'b0;
        repeat (3) step();
        rd_req = 1'b1; rd_addr = AW'(5);
        #1;
        check_val("rd_accept_ready", 32'(rd_ready), 1);
        check_val("rd_accept_addr", 32'(ram_addr), 5);
        check_val("rd_accept_we", 32'(ram_we), 0);
        step(); rd_req = 1'b0; #1;
        check_val("rd_valid_next", 32'(rd_valid), 1);
        check_val("rd_data_abcd", 32'(rd_data), 32'hABCD);
        step(); #1;
        check_val("rd_valid_single", 32'(rd_valid), 0);

        // Out-of-range read address passes through, then is held while idle
        rd_req = 1'b1; rd_addr = AW'(900);
        #1;
        check_val("oor_addr_pass", 32'(ram_addr), 900);
        step(); rd_req = 1'b0; #1;
        check_val("idle_addr_hold", 32'(ram_addr), 900);
        check_val("idle_we", 32'(ram_we), 0);
        step();

        // Continuous reads with 6 back-to-back writes
        base = wlog_addr.size();
        acc = 0; drop_seen = 1'b0; prev_acc = 1'b0;
        for (int k = 0; k < 14; k++) begin
            step();
            rd_req = 1'b1; rd_addr = AW'(k % 6);
            wr_valid = (acc < 6); wr_data = 16'(32'h2000 + acc); wr_sof = 1'b0;
            #1;
            check_val("rd_valid_pulse", 32'(rd_valid), 32'(prev_acc));
            if (rd_valid && exp_q.size() > 0)
                check_val("rd_stream_data", 32'(rd_data), pre_val(exp_q.pop_front()));
            if (!wr_ready && !drop_seen) begin
                drop_seen = 1'b1;
                check_val("accepts_before_full", 32'(acc), 4);
                check_val("rd_ready_when_full", 32'(rd_ready), 0);
                check_val("ram_we_when_full", 32'(ram_we), 1);
            end
            prev_acc = rd_req && rd_ready;
            if (prev_acc) exp_q.push_back(int'(rd_addr));
            if (wr_valid && wr_ready) acc++;
        end
        step(); rd_req = 1'b0; wr_valid = 1'b0; #1;
        check_val("rd_valid_last", 32'(rd_valid), 32'(prev_acc));
        if (rd_valid && exp_q.size() > 0)
            check_val("rd_stream_data", 32'(rd_data), pre_val(exp_q.pop_front()));
        check_val("full_was_seen", 32'(drop_seen), 1);
        check_val("burst_accepted", 32'(acc), 6);
        check_val("rd_results_left", 32'(exp_q.size()), 0);
        repeat (6) step();
        check_val("burst_write_count", 32'(wlog_addr.size() - base), 6);
        bad = 0;
        for (int j = 0; j < 6 && base + j < wlog_addr.size(); j++)
            if (wlog_addr[base + j] != AW'(6 + j) || wlog_data[base + j] != 16'(32'h2000 + j)) bad++;
        check_val("burst_order_bad", 32'(bad), 0);

        // sof mid-frame at pixel 100
        base = wlog_addr.size();
        done_before = done_cnt;
        for (int i = 0; i < 106; i++) begin
            step();
            wr_valid = 1'b1; wr_data = 16'(32'h4000 + i); wr_sof = (i == 100);
        end
        step(); wr_valid = 1'b0; wr_sof = 1'b0;
        repeat (3) step();
        check_val("sof_mid_count", 32'(wlog_addr.size() - base), 106);
        bad = 0;
        for (int j = 0; j < 106 && base + j < wlog_addr.size(); j++)
            if (wlog_addr[base + j] != ((j < 100) ? AW'(12 + j) : AW'(j - 100)) ||
                wlog_data[base + j] != 16'(32'h4000 + j)) bad++;
        check_val("sof_mid_bad", 32'(bad), 0);
        check_val("sof_mid_no_done", 32'(done_cnt - done_before), 0);
        check_val("sof_mid_frame_cnt", 32'(frame_cnt), 1);

        // Asynchronous reset with 3 pixels queued behind reads
        base = wlog_addr.size();
        step(); rd_req = 1'b1; rd_addr = AW'(7); wr_valid = 1'b1; wr_sof = 1'b0; wr_data = 16'h5000;
        step(); wr_data = 16'h5001;
        step(); wr_data = 16'h5002;
        step(); wr_valid = 1'b0;
        #1;
        check_val("queued_no_write", 32'(ram_we), 0);
        check_val("queued_rd_valid", 32'(rd_valid), 1);
        #1;
        rst_n = 1'b0; rd_req = 1'b0;
        #1;
        check_val("arst_wr_ready", 32'(wr_ready), 1);
        check_val("arst_rd_ready", 32'(rd_ready), 1);
        check_val("arst_rd_valid", 32'(rd_valid), 0);
        check_val("arst_ram_we", 32'(ram_we), 0);
        check_val("arst_ram_addr", 32'(ram_addr), 0);
        check_val("arst_frame_cnt", 32'(frame_cnt), 0);
        step(); step();
        rst_n = 1'b1;
        step(); wr_valid = 1'b1; wr_data = 16'h3333; wr_sof = 1'b0;
        step(); wr_valid = 1'b0;
        repeat (3) step();
        check_val("post_rst_writes", 32'(wlog_addr.size() - base), 1);
        check_val("post_rst_addr", 32'(wlog_addr[base]), 0);
        check_val("post_rst_data", 32'(wlog_data[base]), 32'h3333);

        // 256 small frames on the second instance: counter wraps to 0
        for (int i = 0; i < 255 * SFP; i++) begin
            step();
            s_wr_valid = 1'b1; s_wr_data = DW'(i); s_wr_sof = (i == 0);
        end
        step(); s_wr_valid = 1'b0; s_wr_sof = 1'b0;
        repeat (3) step();
        check_val("wrap_cnt_255", 32'(s_frame_cnt), 255);
        check_val("wrap_done_255", 32'(s_done_cnt), 255);
        for (int i = 0; i < SFP; i++) begin
            step();
            s_wr_valid = 1'b1; s_wr_data = DW'(i);
        end
        step(); s_wr_valid = 1'b0;
        repeat (3) step();
        check_val("wrap_cnt_0", 32'(s_frame_cnt), 0);
        check_val("wrap_done_256", 32'(s_done_cnt), 256);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
